alu_requester: RTL and testbench
================================

Name: alu_requester

Overview:
- Initiator side of the single-cycle ALU start/done interface.
- Accepts operation commands from an upstream valid/ready channel and drives the ALU's start/op/A/B inputs.
- Waits for done, captures the 16-bit result, and returns result plus status on a downstream valid/ready channel.
- Sits between the stimulus/command source and the ALU; exactly one command in flight at a time.

Parameters:
TIMEOUT_CYCLES, 8, max cycles in WAIT without alu_done before reporting a timeout; legal range ≥2.
DATA_W, 8, operand width; result width is 2*DATA_W.

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  upstream command valid
cmd_ready  output  1  requester can accept a command
cmd_op  input  3  operation code: 000 NOP, 001 ADD, 010 AND, 011 XOR, 100-111 reserved
cmd_a  input  DATA_W  operand A
cmd_b  input  DATA_W  operand B
alu_start  output  1  one-cycle start pulse to ALU
alu_op  output  3  op to ALU, stable from ISSUE until return to IDLE
alu_a  output  DATA_W  operand A to ALU
alu_b  output  DATA_W  operand B to ALU
alu_done  input  1  ALU completion
alu_result  input  2*DATA_W  ALU result, valid when alu_done=1
rsp_valid  output  1  response valid
rsp_ready  input  1  downstream accepts response
rsp_result  output  2*DATA_W  captured result
rsp_status  output  2  00 OK, 01 NOP, 10 TIMEOUT, 11 MISMATCH
mismatch_cnt  output  8  saturating count of MISMATCH responses

Behaviour:
- Reset (async, rst_n=0): state IDLE; cmd_ready=0 while rst_n=0; alu_start=0; alu_op/alu_a/alu_b=0; rsp_valid=0; rsp_result=0; rsp_status=00; mismatch_cnt=0; timer=0. Reset mid-operation abandons the command with no response and drops alu_start immediately.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register op/a/b onto alu_op/alu_a/alu_b.
  - op==000: go to RESP with rsp_result=0, status 01. No start is issued; the ALU never signals done for NOP.
  - Any other op, including reserved: go to ISSUE.
- ISSUE: alu_start=1 for exactly one cycle; timer cleared; go to WAIT.
- WAIT:
  - alu_start=0; timer increments each cycle.
  - alu_done=1: capture alu_result, status 00, go to RESP.
  - Otherwise, when timer==TIMEOUT_CYCLES-1: rsp_result=0, status 10, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid=1; rsp_result and rsp_status held stable until rsp_ready=1.
  - On handshake, go to IDLE; cmd_ready asserts the following cycle. No back-to-back accept in the RESP handshake cycle.
- cmd_ready=0 in ISSUE, WAIT and RESP.
- Latency: command accepted at edge T → alu_start high in cycle T+1 → alu_done seen in cycle T+2 → rsp_valid high in cycle T+3. NOP: rsp_valid in cycle T+1.
- Reserved ops: ALU returns done with result 0 → reported as status 00, result 0.
- alu_done outside WAIT is ignored.

Optional Feature:
ALU_REQUESTER_CHECK_EN:
- Defined:
  - An internal reference model computes the expected result from the captured op/a/b:
    - ADD: zero-extended DATA_W+1-bit sum.
    - AND/XOR: zero-extended bitwise result.
    - Reserved ops: 0.
  - On alu_done, a captured result different from expected gives status 11 and increments mismatch_cnt, saturating at 255.
- Undefined: no model is instantiated; status 11 is never produced; mismatch_cnt is tied to 0.

Decomposition:
- Package alu_req_pkg:
  - op constants OP_NOP/OP_ADD/OP_AND/OP_XOR.
  - status constants ST_OK/ST_NOP/ST_TIMEOUT/ST_MISMATCH.
  - FSM state typedef.
  - Timer width computed as $clog2(TIMEOUT_CYCLES+1).
- Sub-module alu_ref_model: combinational expected-result function, instantiated only under ALU_REQUESTER_CHECK_EN.

Test Plan:
- ADD a=8'hFF b=8'h01, rsp_ready=1 → alu_start high exactly one cycle; rsp_valid at T+3; rsp_result=16'h0100; status 00.
- NOP a=5 b=7 → no alu_start; rsp_valid at T+1; result 0; status 01.
- XOR 8'hA5^8'h0F with an ALU model that never asserts done, TIMEOUT_CYCLES=8 → response after 8 WAIT cycles; result 0; status 10.
- AND 8'hF0&8'h3C with rsp_ready low for 5 cycles → rsp_valid held; result 16'h0030 stable; cmd_ready=0 throughout; next command accepted the cycle after the handshake.
- rst_n pulsed low during WAIT of an ADD → alu_start/rsp_valid immediately 0; state IDLE; no response emitted; next command executes normally.
- With ALU_REQUESTER_CHECK_EN, ALU model forced to return 16'h0001 for ADD 2+2 → status 11; mismatch_cnt=1. Without the macro → status 00; mismatch_cnt=0.

Source files
------------

// File: rtl/alu_req_pkg.sv
// alu_req_pkg: op/status encodings, FSM state constants and timer sizing shared by the ALU requester.
package alu_req_pkg;
    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_NOP      = 2'b01;
    localparam logic [1:0] ST_TIMEOUT  = 2'b10;
    localparam logic [1:0] ST_MISMATCH = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_ISSUE = 2'd1;
    localparam state_t S_WAIT  = 2'd2;
    localparam state_t S_RESP  = 2'd3;

    function automatic int timer_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction
endpackage

// File: rtl/alu_ref_model.sv
// alu_ref_model: combinational expected ALU result for a captured op/a/b.
module alu_ref_model
    import alu_req_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]          op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] expected
);
    logic [DATA_W:0] sum;
    assign sum = {1'b0, a} + {1'b0, b};
    assign expected = op == OP_ADD ? {{(DATA_W-1){1'b0}}, sum} :
                      op == OP_AND ? {{DATA_W{1'b0}}, a & b} :
                      op == OP_XOR ? {{DATA_W{1'b0}}, a ^ b} : '0;
endmodule

// File: rtl/alu_requester.sv
// alu_requester: initiator for the start/done ALU interface with valid/ready command and response channels.
// Define ALU_REQUESTER_CHECK_EN to check every ALU result against alu_ref_model and count mismatches.
module alu_requester
    import alu_req_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [DATA_W-1:0]   cmd_a,
    input  logic [DATA_W-1:0]   cmd_b,
    output logic                alu_start,
    output logic [2:0]          alu_op,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    input  logic                alu_done,
    input  logic [2*DATA_W-1:0] alu_result,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2*DATA_W-1:0] rsp_result,
    output logic [1:0]          rsp_status,
    output logic [7:0]          mismatch_cnt
);
    localparam int TW = timer_w(TIMEOUT_CYCLES);

    state_t        state;
    logic [TW-1:0] timer;
    logic          mismatch;

    // Decoded from state so an async reset drops them at once.
    assign cmd_ready = rst_n && state == S_IDLE;
    assign alu_start = state == S_ISSUE;
    assign rsp_valid = state == S_RESP;

`ifdef ALU_REQUESTER_CHECK_EN
    logic [2*DATA_W-1:0] exp_result;
    alu_ref_model #(.DATA_W(DATA_W)) u_ref (
        .op(alu_op),
        .a(alu_a),
        .b(alu_b),
        .expected(exp_result)
    );
    assign mismatch = alu_result != exp_result;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mismatch_cnt <= '0;
        else if (state == S_WAIT && alu_done && mismatch && mismatch_cnt != 8'hFF)
            mismatch_cnt <= mismatch_cnt + 8'd1;
    end
`else
    assign mismatch = 1'b0;
    assign mismatch_cnt = 8'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_result <= '0;
            rsp_status <= ST_OK;
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    alu_op <= cmd_op;
                    alu_a  <= cmd_a;
                    alu_b  <= cmd_b;
                    if (cmd_op == OP_NOP) begin
                        rsp_result <= '0;
                        rsp_status <= ST_NOP;
                        state      <= S_RESP;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    // A done arriving on the last allowed cycle still counts.
                    if (alu_done) begin
                        rsp_result <= alu_result;
                        rsp_status <= mismatch ? ST_MISMATCH : ST_OK;
                        state      <= S_RESP;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_result <= '0;
                        rsp_status <= ST_TIMEOUT;
                        state      <= S_RESP;
                    end
                end
                S_RESP: if (rsp_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_requester.sv
// tb_alu_requester: directed scoreboard bench for alu_requester with a delay-programmable ALU model.
module tb_alu_requester;
    import alu_req_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        rsp_ready = 1'b1;
    logic [2:0]  cmd_op = 3'd0;
    logic [7:0]  cmd_a = 8'd0;
    logic [7:0]  cmd_b = 8'd0;
    logic        cmd_ready, alu_start, alu_done, rsp_valid;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a, alu_b, mismatch_cnt;
    logic [15:0] alu_result, rsp_result;
    logic [1:0]  rsp_status;

    int          errors = 0;
    int          checks = 0;
    int          starts = 0;
    logic [17:0] sb[$];

    logic        alu_en = 1'b1;
    logic        bad = 1'b0;
    int          dly = 0;
    logic        pend;
    int          cnt;

`ifdef ALU_REQUESTER_CHECK_EN
    localparam logic [1:0] BAD_ST  = ST_MISMATCH;
    localparam logic [7:0] BAD_CNT = 8'd1;
`else
    localparam logic [1:0] BAD_ST  = ST_OK;
    localparam logic [7:0] BAD_CNT = 8'd0;
`endif

    always #5 clk = ~clk;

    alu_requester #(.TIMEOUT_CYCLES(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_status(rsp_status),
        .mismatch_cnt(mismatch_cnt)
    );

    // ALU model: done appears dly cycles after the cycle following the start pulse.
    always @(posedge clk) begin
        if (!rst_n || !alu_en) pend <= 1'b0;
        else if (alu_start) begin
            pend <= 1'b1;
            cnt  <= 0;
        end else if (pend) begin
            cnt <= cnt + 1;
            if (alu_done) pend <= 1'b0;
        end
    end
    assign alu_done   = pend && alu_en && cnt == dly;
    assign alu_result = bad ? 16'h0001 :
                        alu_op == OP_ADD ? 16'(alu_a) + 16'(alu_b) :
                        alu_op == OP_AND ? 16'(alu_a & alu_b) :
                        alu_op == OP_XOR ? 16'(alu_a ^ alu_b) : 16'h0000;

    always @(posedge clk) if (alu_start) starts++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic check_rsp(input string tag);
        logic [17:0] e;
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_sb"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_result"}, rsp_result, e[17:2]);
            check({tag, "_status"}, rsp_status, e[1:0]);
        end
    endtask

    task automatic wait_rsp(input string tag, output int n);
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_rsp(tag);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int s0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_alu_start", alu_start, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_status", rsp_status, 0);
        check("rst_mismatch_cnt", mismatch_cnt, 0);
        check("rst_alu_op", alu_op, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);

        sb.push_back({16'h0100, ST_OK});
        accept(OP_ADD, 8'hFF, 8'h01);
        check("add_start_t1", alu_start, 1);
        check("add_ready_t1", cmd_ready, 0);
        check("add_alu_op", alu_op, 3'(OP_ADD));
        check("add_alu_a", alu_a, 8'hFF);
        check("add_alu_b", alu_b, 8'h01);
        @(negedge clk);
        check("add_start_t2", alu_start, 0);
        check("add_valid_t2", rsp_valid, 0);
        @(negedge clk);
        check_rsp("add_t3");
        check("add_starts", starts, 1);
        @(negedge clk);
        check("add_after_valid", rsp_valid, 0);
        check("add_after_ready", cmd_ready, 1);

        sb.push_back({16'h0000, ST_NOP});
        accept(OP_NOP, 8'd5, 8'd7);
        check_rsp("nop_t1");
        check("nop_start", alu_start, 0);
        @(negedge clk);
        check("nop_starts", starts, 1);

        alu_en = 1'b0;
        sb.push_back({16'h0000, ST_TIMEOUT});
        accept(OP_XOR, 8'hA5, 8'h0F);
        wait_rsp("xor_tmo", n);
        check("xor_tmo_latency", n, 10);
        check("xor_tmo_op_held", alu_op, 3'(OP_XOR));
        @(negedge clk);
        alu_en = 1'b1;

        dly = 7;
        sb.push_back({16'h0011, ST_OK});
        accept(OP_XOR, 8'h22, 8'h33);
        wait_rsp("done_last_cycle", n);
        check("done_last_latency", n, 10);

        dly = 8;
        sb.push_back({16'h0000, ST_TIMEOUT});
        accept(OP_ADD, 8'd1, 8'd1);
        wait_rsp("done_too_late", n);
        check("done_late_latency", n, 10);
        @(negedge clk);
        check("late_done_ignored_valid", rsp_valid, 0);
        check("late_done_ignored_ready", cmd_ready, 1);
        dly = 0;

        rsp_ready = 1'b0;
        sb.push_back({16'h0030, ST_OK});
        accept(OP_AND, 8'hF0, 8'h3C);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", rsp_valid, 1);
            check("bp_result", rsp_result, 16'h0030);
            check("bp_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        check_rsp("bp");
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = OP_NOP;
        cmd_a = 8'd1;
        cmd_b = 8'd2;
        sb.push_back({16'h0000, ST_NOP});
        @(negedge clk);
        check("bp_hs_valid", rsp_valid, 0);
        check("bp_hs_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_rsp("bp_next");
        @(negedge clk);

        s0 = starts;
        sb.push_back({16'h0000, ST_OK});
        accept(3'b101, 8'h09, 8'h09);
        wait_rsp("reserved", n);
        check("reserved_latency", n, 3);
        check("reserved_started", starts, s0 + 1);
        @(negedge clk);

        alu_en = 1'b0;
        accept(OP_ADD, 8'h10, 8'h20);
        @(negedge clk);
        @(negedge clk);
        check("mid_wait_valid", rsp_valid, 0);
        rst_n = 1'b0;
        #1;
        check("arst_alu_start", alu_start, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_cmd_ready", cmd_ready, 0);
        check("arst_alu_op", alu_op, 0);
        @(negedge clk);
        rst_n = 1'b1;
        alu_en = 1'b1;
        @(negedge clk);
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_valid", rsp_valid, 0);
        sb.push_back({16'h0030, ST_OK});
        accept(OP_ADD, 8'h10, 8'h20);
        wait_rsp("post_rst_add", n);
        check("post_rst_latency", n, 3);
        @(negedge clk);

        bad = 1'b1;
        sb.push_back({16'h0001, BAD_ST});
        accept(OP_ADD, 8'd2, 8'd2);
        wait_rsp("bad_add", n);
        bad = 1'b0;
        check("bad_mismatch_cnt", mismatch_cnt, BAD_CNT);
        @(negedge clk);
        sb.push_back({16'h0004, ST_OK});
        accept(OP_ADD, 8'd2, 8'd2);
        wait_rsp("good_add", n);
        check("good_mismatch_cnt", mismatch_cnt, BAD_CNT);
        @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
